// File: rtl/modn_sync_counter.sv
// Fully synchronous modulo-MODULUS counter with enable, parallel load and cascade flags.
// Optional feature macro: MODN_CNT_UPDOWN_EN adds the dir input for up/down counting.
module modn_sync_counter #(
    parameter int unsigned MODULUS   = 10,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MODN_CNT_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Limits held one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

    if (MODULUS < 2) begin : g_err_mod_small
        $error("modn_sync_counter: MODULUS must be at least 2");
    end
    if (64'(MODULUS) > (64'(1) << WIDTH)) begin : g_err_mod_wide
        $error("modn_sync_counter: 2**WIDTH must be >= MODULUS");
    end
    if (RESET_VAL >= MODULUS) begin : g_err_rst_val
        $error("modn_sync_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic [WIDTH:0]   term_x;
    logic             count_up;
    logic             at_last;
    logic             at_zero;

`ifdef MODN_CNT_UPDOWN_EN
    assign count_up = dir;
`else
    assign count_up = 1'b1;
`endif

    assign cnt_x   = {1'b0, cnt_q};
    assign load_x  = {1'b0, load_val};
    assign inc_x   = cnt_x + (WIDTH+1)'(1);
    assign dec_x   = cnt_x - (WIDTH+1)'(1);
    assign at_last = (cnt_x == LAST_X);
    assign at_zero = (cnt_q == '0);
    assign term_x  = count_up ? LAST_X : '0;

    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // Out-of-range loads are clamped to 0 so cnt never leaves the legal range.
            if (load_x >= MOD_X) begin
                cnt_d      = '0;
                load_err_d = 1'b1;
            end else begin
                cnt_d = load_val;
            end
        end else if (en) begin
            if (count_up) begin
                if (at_last) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = inc_x[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = LAST_X[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = dec_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= RST_V;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // tc is the cascade enable for the next stage, so it must not wait a cycle.
    assign tc       = en && (cnt_x == term_x);
    assign cnt      = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_sync_counter.sv
// Randomised and directed bench for modn_sync_counter against a modular-arithmetic reference.
module tb_modn_sync_counter;

    localparam int MOD = 10;
    localparam int W   = 4;
    localparam int RV  = 0;

    logic         clk = 1'b0;
    logic         rst, en, load, dir;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         tc, wrap, load_err;

    logic         c_rst, c_en;
    logic [W-1:0] c0_cnt, c1_cnt;
    logic         c0_tc, c1_tc, c0_wrap, c1_wrap, c0_err, c1_err;

    int total = 0;
    int bad   = 0;
    int m_cnt;
    bit m_wrap, m_err;

    always #5 clk = ~clk;

    modn_sync_counter #(.MODULUS(MOD), .WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
`ifdef MODN_CNT_UPDOWN_EN
        .dir(dir),
`endif
        .cnt(cnt), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    modn_sync_counter #(.MODULUS(MOD), .WIDTH(W), .RESET_VAL(0)) u_stage0 (
        .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .load_val('0),
`ifdef MODN_CNT_UPDOWN_EN
        .dir(1'b1),
`endif
        .cnt(c0_cnt), .tc(c0_tc), .wrap(c0_wrap), .load_err(c0_err)
    );

    modn_sync_counter #(.MODULUS(MOD), .WIDTH(W), .RESET_VAL(0)) u_stage1 (
        .clk(clk), .rst(c_rst), .en(c0_tc), .load(1'b0), .load_val('0),
`ifdef MODN_CNT_UPDOWN_EN
        .dir(1'b1),
`endif
        .cnt(c1_cnt), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_err)
    );

    function automatic bit going_up();
`ifdef MODN_CNT_UPDOWN_EN
        return dir;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_tc();
        int term;
        term = going_up() ? MOD - 1 : 0;
        return en && (m_cnt == term);
    endfunction

    // Reference: next count from rst > load > en > hold using plain modular arithmetic.
    task automatic tick();
        int nx;
        bit w, e;
        nx = m_cnt; w = 0; e = 0;
        if (rst) nx = RV;
        else if (load) begin
            if (int'(load_val) >= MOD) begin nx = 0; e = 1; end
            else nx = int'(load_val);
        end else if (en) begin
            if (going_up()) begin w = (m_cnt == MOD - 1); nx = (m_cnt + 1) % MOD; end
            else begin w = (m_cnt == 0); nx = (m_cnt + MOD - 1) % MOD; end
        end
        @(posedge clk);
        m_cnt = nx; m_wrap = w; m_err = e;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; load = 1; load_val = 4'd7; dir = 1;
        tick(); tick();
        en = 0; load = 0;
        #1;
        total++;
        if (cnt !== W'(RV) || wrap !== 1'b0 || load_err !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset cnt=%0d wrap=%b err=%b tc=%b exp cnt=%0d 0 0 0", cnt, wrap, load_err, tc, RV);
        end
        rst = 0;
    endtask

    task automatic test_count();
        en = 1; load = 0; dir = 1;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (tc !== exp_tc()) begin
                bad++; $display("FAIL count_tc i=%0d got=%b exp=%b", i, tc, exp_tc());
            end
            tick();
            total++;
            if (cnt !== W'(m_cnt) || wrap !== m_wrap) begin
                bad++; $display("FAIL count i=%0d cnt=%0d wrap=%b exp %0d %b", i, cnt, wrap, m_cnt, m_wrap);
            end
        end
        en = 0;
    endtask

    task automatic test_hold();
        load = 1; load_val = 4'd4; en = 0; tick();
        load = 0; en = 1; tick();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cnt !== 4'd5 || tc !== 1'b0 || wrap !== 1'b0) begin
                bad++; $display("FAIL hold i=%0d cnt=%0d tc=%b wrap=%b exp 5 0 0", i, cnt, tc, wrap);
            end
        end
    endtask

    task automatic test_load();
        load = 1; load_val = 4'd7; en = 1; tick();
        total++;
        if (cnt !== 4'd7 || load_err !== 1'b0) begin
            bad++; $display("FAIL load_wins cnt=%0d err=%b exp 7 0", cnt, load_err);
        end
        load = 0; tick();
        total++;
        if (cnt !== 4'd8) begin bad++; $display("FAIL load_then_step cnt=%0d exp 8", cnt); end
        // Load landing on the wrap point must suppress wrap.
        tick();
        load = 1; load_val = 4'd3; tick();
        total++;
        if (cnt !== 4'd3 || wrap !== 1'b0) begin
            bad++; $display("FAIL load_at_term cnt=%0d wrap=%b exp 3 0", cnt, wrap);
        end
        load = 0; en = 0;
    endtask

    task automatic test_load_err();
        logic [W-1:0] vals [4];
        vals[0] = 4'd12; vals[1] = 4'd9; vals[2] = 4'd10; vals[3] = 4'd15;
        for (int i = 0; i < 4; i++) begin
            load = 1; load_val = vals[i]; en = 0; tick();
            total++;
            if (cnt !== W'(m_cnt) || load_err !== m_err) begin
                bad++; $display("FAIL load_err v=%0d cnt=%0d err=%b exp %0d %b", vals[i], cnt, load_err, m_cnt, m_err);
            end
            load = 0; tick();
            total++;
            if (load_err !== 1'b0) begin bad++; $display("FAIL load_err_pulse v=%0d err=%b exp 0", vals[i], load_err); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 7) == 0);
            en = $urandom_range(0, 3) != 0;
            load_val = W'($urandom_range(0, 15));
`ifdef MODN_CNT_UPDOWN_EN
            dir = $urandom_range(0, 1);
`endif
            #1;
            total++;
            if (tc !== exp_tc()) begin bad++; $display("FAIL rand_tc i=%0d got=%b exp=%b", i, tc, exp_tc()); end
            tick();
            total++;
            if (cnt !== W'(m_cnt) || wrap !== m_wrap || load_err !== m_err) begin
                bad++;
                $display("FAIL rand i=%0d cnt=%0d wrap=%b err=%b exp %0d %b %b", i, cnt, wrap, load_err, m_cnt, m_wrap, m_err);
            end
        end
        rst = 0; load = 0; en = 0; dir = 1;
    endtask

    task automatic test_mid_reset();
        load = 1; load_val = 4'd6; tick();
        load = 0; en = 1; rst = 1; tick();
        rst = 0; en = 0;
        total++;
        if (cnt !== W'(RV) || wrap !== 1'b0) begin
            bad++; $display("FAIL mid_reset cnt=%0d wrap=%b exp %0d 0", cnt, wrap, RV);
        end
    endtask

    task automatic test_cascade();
        c_rst = 1; c_en = 0;
        @(posedge clk); @(posedge clk); #1;
        c_rst = 0; c_en = 1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            total++;
            if (c0_cnt !== W'(n % 10) || c1_cnt !== W'((n / 10) % 10)) begin
                bad++; $display("FAIL cascade n=%0d got=%0d,%0d exp=%0d,%0d", n, c1_cnt, c0_cnt, (n / 10) % 10, n % 10);
            end
        end
        c_en = 0;
    endtask

`ifdef MODN_CNT_UPDOWN_EN
    task automatic test_updown();
        rst = 1; tick(); rst = 0;
        dir = 0; en = 1; #1;
        total++;
        if (tc !== 1'b1) begin bad++; $display("FAIL down_tc got=%b exp=1", tc); end
        tick();
        total++;
        if (cnt !== 4'd9 || wrap !== 1'b1) begin bad++; $display("FAIL down_wrap cnt=%0d wrap=%b exp 9 1", cnt, wrap); end
        tick();
        total++;
        if (cnt !== 4'd8 || wrap !== 1'b0) begin bad++; $display("FAIL down_step cnt=%0d wrap=%b exp 8 0", cnt, wrap); end
        dir = 1; en = 0;
    endtask
`endif

    initial begin
        rst = 1; en = 0; load = 0; load_val = '0; dir = 1;
        c_rst = 1; c_en = 0;
        m_cnt = RV; m_wrap = 0; m_err = 0;
        test_reset();
        test_count();
        test_hold();
        test_load();
        test_load_err();
        test_mid_reset();
`ifdef MODN_CNT_UPDOWN_EN
        test_updown();
`endif
        test_random();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
